// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one combinational ALU between two requesters; optional ALU_ARB_OPCOUNT_EN adds per-port op counters
module alu_arbiter #(
  parameter int bus_size = 8,
  parameter int shamt_p  = 3
`ifdef ALU_ARB_OPCOUNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_0,
  input  logic                req_valid_1,
  output logic                req_ready_0,
  output logic                req_ready_1,
  input  logic [bus_size-1:0] req_a_0,
  input  logic [bus_size-1:0] req_a_1,
  input  logic [bus_size-1:0] req_b_0,
  input  logic [bus_size-1:0] req_b_1,
  input  logic [2:0]          req_sel_0,
  input  logic [2:0]          req_sel_1,
  input  logic [shamt_p-1:0]  req_shamt_0,
  input  logic [shamt_p-1:0]  req_shamt_1,
  output logic                resp_valid_0,
  output logic                resp_valid_1,
  input  logic                resp_ready_0,
  input  logic                resp_ready_1,
  output logic [bus_size-1:0] resp_s,
  output logic [3:0]          resp_flags,
  output logic [bus_size-1:0] alu_a,
  output logic [bus_size-1:0] alu_b,
  output logic [2:0]          alu_sel,
  output logic [shamt_p-1:0]  alu_shamt,
  input  logic [bus_size-1:0] alu_s,
`ifdef ALU_ARB_OPCOUNT_EN
  output logic [CNT_W-1:0]    op_count_0,
  output logic [CNT_W-1:0]    op_count_1,
`endif
  input  logic [3:0]          alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;      // port currently being served
  logic   last;       // port granted most recently
  logic   grant_0;
  logic   grant_1;
  logic   resp_done;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_0 = last;
      grant_1 = ~last;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  // Ready is offered only while idle and never while reset is held
  assign req_ready_0 = rst_n && (state == IDLE) && grant_0;
  assign req_ready_1 = rst_n && (state == IDLE) && grant_1;

  assign resp_done = (state == RESP) && (owner ? resp_ready_1 : resp_ready_0);

  // Control FSM: latch the winner's operands, capture the ALU one cycle later, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      resp_valid_0 <= 1'b0;
      resp_valid_1 <= 1'b0;
      resp_s       <= '0;
      resp_flags   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      alu_shamt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_0) begin
            alu_a     <= req_a_0;
            alu_b     <= req_b_0;
            alu_sel   <= req_sel_0;
            alu_shamt <= req_shamt_0;
            owner     <= 1'b0;
            last      <= 1'b0;
            state     <= EXEC;
          end else if (grant_1) begin
            alu_a     <= req_a_1;
            alu_b     <= req_b_1;
            alu_sel   <= req_sel_1;
            alu_shamt <= req_shamt_1;
            owner     <= 1'b1;
            last      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          resp_s       <= alu_s;
          resp_flags   <= alu_flags;
          resp_valid_0 <= ~owner;
          resp_valid_1 <= owner;
          state        <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_OPCOUNT_EN
  // Saturating per-port count of completed response handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_0 <= '0;
      op_count_1 <= '0;
    end else if (resp_done) begin
      if (!owner && (op_count_0 != {CNT_W{1'b1}}))
        op_count_0 <= op_count_0 + CNT_W'(1);
      if (owner && (op_count_1 != {CNT_W{1'b1}}))
        op_count_1 <= op_count_1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and transaction model
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [7:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [2:0] req_sel_0, req_sel_1, req_shamt_0, req_shamt_1;
  logic       resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
  logic [7:0] resp_s, alu_a, alu_b, alu_s;
  logic [3:0] resp_flags, alu_flags;
  logic [2:0] alu_sel, alu_shamt;
`ifdef ALU_ARB_OPCOUNT_EN
  logic [1:0] op_count_0, op_count_1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .bus_size(8),
    .shamt_p(3)
`ifdef ALU_ARB_OPCOUNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_sel_0(req_sel_0), .req_sel_1(req_sel_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_s(resp_s), .resp_flags(resp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
    .alu_s(alu_s),
`ifdef ALU_ARB_OPCOUNT_EN
    .op_count_0(op_count_0), .op_count_1(op_count_1),
`endif
    .alu_flags(alu_flags)
  );

  // Reference ALU: returns {s, overflow, zero, negative, carry_out}
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel, input logic [2:0] sh);
    logic [8:0] w;
    logic [7:0] s;
    logic       c, v;
    c = 1'b0; v = 1'b0; w = '0;
    case (sel)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; s = w[7:0]; c = w[8];
                  v = (a[7] == b[7]) && (s[7] != a[7]); end
      3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 9'd1; s = w[7:0]; c = w[8];
                  v = (a[7] != b[7]) && (s[7] != a[7]); end
      3'd2: s = a << sh;
      3'd3: s = a >> sh;
      3'd4: s = a | b;
      3'd5: s = a & b;
      3'd6: s = a ^ b;
      default: s = ~a;
    endcase
    return {s, v, (s == 8'h00), s[7], c};
  endfunction

  always_comb {alu_s, alu_flags} = alu_ref(alu_a, alu_b, alu_sel, alu_shamt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid_0 = 0; req_valid_1 = 0;
    req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
    req_sel_0 = 0; req_sel_1 = 0; req_shamt_0 = 0; req_shamt_1 = 0;
    resp_ready_0 = 1; resp_ready_1 = 1;
  endtask

  task automatic set_req(input bit p, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel, input logic [2:0] sh, input bit v);
    if (!p) begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_sel_0 = sel; req_shamt_0 = sh;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_sel_1 = sel; req_shamt_1 = sh;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // One isolated operation on port p with resp_ready held high
  task automatic do_single(input bit p, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sel, input logic [2:0] sh,
                           input logic [7:0] es, input logic [3:0] ef);
    @(negedge clk);
    set_req(p, a, b, sel, sh, 1);
    #1;
    check("single_ready", p ? req_ready_1 : req_ready_0, 1);
    check("single_ready_other", p ? req_ready_0 : req_ready_1, 0);
    @(negedge clk);
    set_req(p, 8'h00, 8'h00, 3'd0, 3'd0, 0);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_sel", alu_sel, sel);
    check("exec_alu_shamt", alu_shamt, sh);
    check("exec_no_valid", {resp_valid_1, resp_valid_0}, 0);
    @(negedge clk);
    check("resp_valid_owner", p ? resp_valid_1 : resp_valid_0, 1);
    check("resp_valid_other", p ? resp_valid_0 : resp_valid_1, 0);
    check("resp_s", resp_s, es);
    check("resp_flags", resp_flags, ef);
    @(negedge clk);
    check("resp_cleared", {resp_valid_1, resp_valid_0}, 0);
  endtask

  typedef struct {
    bit         port;
    logic [7:0] a, b;
    logic [2:0] sel, sh;
    logic [7:0] es;
    logic [3:0] ef;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         grants[$];
    int         gcyc[$];
    bit         pend[2];
    logic [7:0] ra[2], rb[2];
    logic [2:0] rsel[2], rsh[2];
    bit         outstanding;
    bit         owner;
    bit         last_srv;
    int         age;
    logic [11:0] exp_res;
    logic [7:0] exp_a;
    bit         e0, e1;

    vecs[0] = '{1'b0, 8'h03, 8'h05, 3'd0, 3'd0, 8'h08, 4'b0000};
    vecs[1] = '{1'b1, 8'h05, 8'h05, 3'd1, 3'd0, 8'h00, 4'b0101};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 3'd0, 3'd0, 8'h80, 4'b1010};
    vecs[3] = '{1'b1, 8'h0F, 8'h00, 3'd7, 3'd0, 8'hF0, 4'b0010};
    vecs[4] = '{1'b0, 8'h81, 8'h00, 3'd2, 3'd1, 8'h02, 4'b0000};
    vecs[5] = '{1'b1, 8'h80, 8'h00, 3'd3, 3'd3, 8'h10, 4'b0000};
    vecs[6] = '{1'b0, 8'hAA, 8'hAA, 3'd6, 3'd0, 8'h00, 4'b0100};
    vecs[7] = '{1'b1, 8'hF0, 8'h0F, 3'd4, 3'd0, 8'hFF, 4'b0010};
    vecs[8] = '{1'b0, 8'hF0, 8'h0F, 3'd5, 3'd0, 8'h00, 4'b0100};
    vecs[9] = '{1'b1, 8'h00, 8'h01, 3'd1, 3'd0, 8'hFF, 4'b0010};

    // Reset state
    idle_inputs();
    #2 rst_n = 0;
    #1;
    check("rst_ready", {req_ready_1, req_ready_0}, 0);
    check("rst_valid", {resp_valid_1, resp_valid_0}, 0);
    check("rst_resp_s", resp_s, 0);
    check("rst_resp_flags", resp_flags, 0);
    check("rst_alu", {alu_a, alu_b, alu_sel, alu_shamt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Table-driven single operations
    for (int i = 0; i < 10; i++)
      do_single(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].sh, vecs[i].es, vecs[i].ef);

    // Both ports continuously valid: grants alternate every 3 cycles
    do_reset();
    set_req(0, 8'hF0, 8'h0F, 3'd4, 3'd0, 1);
    set_req(1, 8'hF0, 8'h0F, 3'd5, 3'd0, 1);
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready_0 || req_ready_1) begin
        grants.push_back(req_ready_1 ? 1 : 0);
        gcyc.push_back(c);
      end
      if (resp_valid_0) check("alt_resp0", resp_s, 8'hFF);
      if (resp_valid_1) check("alt_resp1", resp_s, 8'h00);
      @(negedge clk);
    end
    check("alt_grant_count", (grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
      for (int g = 0; g < 4; g++) check("alt_grant_port", grants[g], g % 2);
      for (int g = 1; g < 4; g++) check("alt_grant_spacing", gcyc[g] - gcyc[g-1], 3);
    end
    idle_inputs();

    // Backpressure on port 0 while port 1 waits
    do_reset();
    resp_ready_0 = 0;
    set_req(0, 8'h11, 8'h22, 3'd0, 3'd0, 1);
    set_req(1, 8'h01, 8'h01, 3'd0, 3'd0, 1);
    #1;
    check("bp_grant0", {req_ready_1, req_ready_0}, 2'b01);
    @(negedge clk);
    req_valid_0 = 0;
    #1;
    check("bp_exec_ready1", req_ready_1, 0);
    @(negedge clk);
    check("bp_resp_valid", resp_valid_0, 1);
    check("bp_resp_s", resp_s, 8'h33);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", resp_valid_0, 1);
      check("bp_hold_s", resp_s, 8'h33);
      check("bp_hold_flags", resp_flags, 4'b0000);
      check("bp_no_ready1", req_ready_1, 0);
      check("bp_alu_a", alu_a, 8'h11);
    end
    resp_ready_0 = 1;
    @(negedge clk);
    #1;
    check("bp_release_valid", resp_valid_0, 0);
    check("bp_release_grant1", req_ready_1, 1);
    @(negedge clk);
    req_valid_1 = 0;
    @(negedge clk);
    check("bp_p1_valid", resp_valid_1, 1);
    check("bp_p1_s", resp_s, 8'h02);
    @(negedge clk);

    // Reset during EXEC: outputs clear at once and port 0 wins afterwards
    set_req(0, 8'h5A, 8'h3C, 3'd6, 3'd5, 1);
    #1;
    check("rmid_grant0", req_ready_0, 1);
    @(negedge clk);
    set_req(1, 8'h01, 8'h02, 3'd0, 3'd0, 1);
    #1;
    check("rmid_exec_alu_a", alu_a, 8'h5A);
    rst_n = 0;
    #1;
    check("rmid_alu", {alu_a, alu_b, alu_sel, alu_shamt}, 0);
    check("rmid_resp", {resp_s, resp_flags}, 0);
    check("rmid_valid", {resp_valid_1, resp_valid_0}, 0);
    check("rmid_ready", {req_ready_1, req_ready_0}, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rmid_first_grant", {req_ready_1, req_ready_0}, 2'b01);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    // Randomized traffic against a transaction-level model
    do_reset();
    pend[0] = 0; pend[1] = 0;
    outstanding = 0; owner = 0; last_srv = 1; age = 0;
    exp_res = '0; exp_a = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (outstanding) age++;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) pend[p] = 1;
        ra[p] = 8'($urandom); rb[p] = 8'($urandom);
        rsel[p] = 3'($urandom); rsh[p] = 3'($urandom);
        set_req(p[0], ra[p], rb[p], rsel[p], rsh[p], pend[p]);
      end
      resp_ready_0 = ($urandom_range(0, 3) != 0);
      resp_ready_1 = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_valid0", resp_valid_0, outstanding && age >= 2 && !owner);
      check("rnd_valid1", resp_valid_1, outstanding && age >= 2 && owner);
      if (outstanding && age >= 2) begin
        check("rnd_resp_s", resp_s, exp_res[11:4]);
        check("rnd_resp_flags", resp_flags, exp_res[3:0]);
      end
      if (outstanding && age >= 1) check("rnd_alu_a", alu_a, exp_a);
      if (outstanding) begin
        e0 = 0; e1 = 0;
      end else if (pend[0] && pend[1]) begin
        e0 = (last_srv == 1); e1 = !e0;
      end else begin
        e0 = pend[0]; e1 = pend[1];
      end
      check("rnd_ready0", req_ready_0, e0);
      check("rnd_ready1", req_ready_1, e1);
      if (outstanding) begin
        if (age >= 2 && (owner ? resp_ready_1 : resp_ready_0)) outstanding = 0;
      end else if (e0 || e1) begin
        owner = e1;
        last_srv = e1;
        exp_res = alu_ref(ra[owner], rb[owner], rsel[owner], rsh[owner]);
        exp_a = ra[owner];
        pend[owner] = 0;
        outstanding = 1;
        age = 0;
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);

`ifdef ALU_ARB_OPCOUNT_EN
    // Saturating operation counters with CNT_W=2
    do_reset();
    #1;
    check("cnt_reset", {op_count_1, op_count_0}, 0);
    do_single(0, 8'h01, 8'h01, 3'd0, 3'd0, 8'h02, 4'b0000);
    check("cnt_one", op_count_0, 1);
    for (int k = 0; k < 4; k++)
      do_single(0, 8'h01, 8'h01, 3'd0, 3'd0, 8'h02, 4'b0000);
    check("cnt_sat0", op_count_0, 3);
    check("cnt_idle1", op_count_1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one ALU instance between two requesters (port 0, port 1) using a round-robin arbiter and a small FSM. It registers the granted request's operands and drives them to the ALU, captures the result and the four flags, and returns them to the owning requester. It uses valid/ready handshakes on both the request and response sides. It sits between the two datapath clients and the combinational ALU (8-function, select encoding 000 add … 111 not).

Parameters:
bus_size, 8, operand/result width; must match the attached ALU.
shamt_p, 3, shift-amount width; 2^shamt_p = bus_size.
CNT_W, 16, width of the optional operation counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active low.
req_valid_0 / req_valid_1  in  1  request valid, per port.
req_ready_0 / req_ready_1  out  1  request accepted this cycle, per port.
req_a_0 / req_a_1  in  bus_size  operand a.
req_b_0 / req_b_1  in  bus_size  operand b.
req_sel_0 / req_sel_1  in  3  ALU function select.
req_shamt_0 / req_shamt_1  in  shamt_p  shift amount.
resp_valid_0 / resp_valid_1  out  1  result valid, per port.
resp_ready_0 / resp_ready_1  in  1  result consumed, per port.
resp_s  out  bus_size  registered result, shared by both ports.
resp_flags  out  4  registered flags {overflow, zero, negative, carry_out}.
alu_a, alu_b  out  bus_size  registered operands to the ALU.
alu_sel  out  3  registered select to the ALU.
alu_shamt  out  shamt_p  registered shift amount to the ALU.
alu_s  in  bus_size  ALU result.
alu_flags  in  4  ALU flags, same bit order as resp_flags.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All ready/valid outputs are 0.
  - resp_s=0, resp_flags=0.
  - alu_a/alu_b/alu_sel/alu_shamt=0.
  - Last-grant pointer=1, so port 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one port has req_valid, that port wins. If both are valid, the port not equal to the last-grant pointer wins.
  - req_ready_x=1 only for the granted port, and only in IDLE. Both req_ready signals are 0 in every other state.
  - On a transfer (valid & ready), register a/b/sel/shamt onto the alu_* outputs, record the owner, update the last-grant pointer, and go to EXEC.
  - With no request pending, stay in IDLE.
- EXEC (exactly 1 cycle):
  - The ALU evaluates the registered operands.
  - At the clock edge, capture alu_s → resp_s and alu_flags → resp_flags, then go to RESP.
- RESP:
  - resp_valid of the owner is 1; the other port's resp_valid is 0.
  - resp_s and resp_flags are held stable while resp_valid=1.
  - When the owner's resp_ready=1, go to IDLE and clear resp_valid at that edge.
  - The other port's resp_ready is ignored.
- Latency and throughput:
  - Request accepted at edge N → resp_valid high after edge N+2 (visible in cycle N+2).
  - Back-to-back throughput is one operation per 3 cycles when resp_ready is held at 1.
- alu_* outputs hold their last values outside EXEC; they are not cleared between operations.
- A request held valid while the other port is being served is not dropped. It stays pending, and req_ready may only rise in IDLE.
- Changing req_* while req_ready=0 has no effect.
- The arbiter does not interpret or modify select codes, flags or data widths; all 8 functions pass through.
- Reset mid-operation: any state returns to IDLE immediately, and an in-flight response is lost. Requesters must reissue.

Optional Feature:
- Macro: ALU_ARB_OPCOUNT_EN.
- Defined:
  - Adds outputs op_count_0 and op_count_1 (CNT_W each).
  - Each counter increments by 1 on every completed response handshake of its port.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Port 0 only: a=0x03, b=0x05, sel=000 → req_ready_0 in cycle 0; resp_valid_0 in cycle 2 with resp_s=0x08, resp_flags[2] (zero)=0.
- Port 1 only: a=0x05, b=0x05, sel=001 → resp_s=0x00, zero=1, carry_out=1, resp_valid_0 stays 0.
- Both valid continuously (p0 sel=100 a=0xF0 b=0x0F; p1 sel=101 a=0xF0 b=0x0F) → grants alternate 0,1,0,1; port 0 gets 0xFF, port 1 gets 0x00; every 3 cycles with resp_ready tied 1.
- Backpressure: resp_ready_0=0 for 5 cycles after resp_valid_0 rises → resp_s and resp_flags stable, no new grant, req_ready_1 stays 0 despite req_valid_1=1; release → IDLE next cycle, then port 1 is granted.
- Reset mid-op: assert rst_n=0 in EXEC → all outputs 0 asynchronously; after release, port 0 wins the first grant.
- ALU_ARB_OPCOUNT_EN defined, CNT_W=2: 5 port-0 ops → op_count_0 saturates at 3, op_count_1=0.
